led_status_ctrl: RTL and testbench
==================================

LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of LED channels.
REQ-002 SHALL have parameter TICK_DIV, default 125000: clk cycles per tick (1 ms at 125 MHz).
REQ-003 SHALL have parameter BLINK_HALF, default 250: ticks per blink half-period.
REQ-004 SHALL have parameter STRETCH, default 50: ticks in each activity ON phase and each GAP phase.
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port mode  in  2*NUM_CH  per-channel mode: 0 OFF, 1 ON, 2 BLINK, 3 ACTIVITY.
REQ-008 SHALL have port act  in  NUM_CH  per-channel activity pulse, sampled every clk.
REQ-009 SHALL have port led  out  NUM_CH  registered LED drive.
REQ-010 SHALL have port tick  out  1  one-cycle tick strobe.

Function
REQ-011 SHALL run a prescaler counting 0..TICK_DIV-1 that wraps to 0 and asserts tick for one cycle when count == TICK_DIV-1.
REQ-012 SHALL run one shared blink counter that toggles a common phase bit on the tick completing BLINK_HALF ticks, so all BLINK channels stay in step.
REQ-013 SHALL drive led 0 in OFF, 1 in ON and the phase bit in BLINK, each one cycle after the mode input is applied.
REQ-014 SHALL implement a per-channel ACTIVITY FSM with states IDLE (led 0), ON (led 1) and GAP (led 0).
REQ-015 SHALL move IDLE->ON when act=1, loading cnt=STRETCH; led reads 1 on the next cycle.
REQ-016 SHALL decrement cnt on each tick in ON/GAP; on a tick with cnt==1, ON->GAP (reload STRETCH) and GAP->IDLE.
REQ-017 SHALL set a pending flag when act=1 in ON or GAP; on GAP exit with pending set, go directly to ON (reload STRETCH) and clear pending.
REQ-018 SHALL NOT count a tick on the same cycle IDLE->ON is taken (act and tick together).
REQ-019 SHALL force the FSM to IDLE with cnt=0 and pending=0 whenever the channel mode is not ACTIVITY.
REQ-020 SHALL ignore act in OFF, ON and BLINK.

Reset
REQ-021 SHALL clear on rst_n=0, asynchronously: prescaler, blink counter and phase, all FSMs (IDLE), cnt, pending, led=0 and tick=0.
REQ-022 SHALL start the prescaler from 0 on the first clk edge after rst_n deasserts; a reset mid-stretch aborts it with no output residue.

Configuration
REQ-023 SHALL, with LED_PWM_EN defined, add port duty  in  4*NUM_CH and a free-running 4-bit pwm counter incremented every clk.
REQ-024 SHALL, with LED_PWM_EN defined, drive led = raw & (pwm_cnt < duty), except duty==15, which gives led = raw.
REQ-025 SHALL, without LED_PWM_EN, omit the duty port and pwm counter and drive led = raw.

Structure
REQ-026 SHALL place the mode encodings (OFF/ON/BLINK/ACTIVITY), FSM state encodings and mode field width in package led_status_pkg.
REQ-027 SHALL implement each channel (mode decode, ACTIVITY FSM, optional PWM gate) in sub-module led_channel, instantiated NUM_CH times.
REQ-028 SHALL keep the prescaler and blink generator in the top module, shared by all channels.

Verification (bench parameters: NUM_CH=4, TICK_DIV=4, BLINK_HALF=3, STRETCH=2)
REQ-029 SHALL cover: hold rst_n=0 with mode=ON -> led=0000, tick=0; release -> first tick on 4th clk, then every 4 clks; reassert mid-run -> led=0000 immediately.
REQ-030 SHALL cover: all channels BLINK -> all led bits equal and toggle every 12 clks.
REQ-031 SHALL cover: ch0 ACTIVITY, one act pulse in IDLE -> led[0]=1 next cycle, held for 2 ticks, 0 for 2 ticks, then stays 0.
REQ-032 SHALL cover: second act pulse during ON -> after the GAP, led[0]=1 again for 2 ticks with no new act; later act during GAP behaves the same.
REQ-033 SHALL cover: mode ACTIVITY->OFF mid-ON -> led=0 next cycle; back to ACTIVITY -> led stays 0 until a new act (pending cleared).
REQ-034 SHALL cover, with LED_PWM_EN: mode ON, duty=4 -> led high 4 of every 16 clks; duty=0 -> always 0; duty=15 -> always 1.

Source files
------------

// File: rtl/led_status_pkg.sv
// led_status_pkg: shared encodings for the LED status controller.
//   MODE_W   - width of one channel's mode field
//   mode_e   - per-channel mode (OFF / ON / BLINK / ACTIVITY)
//   act_st_e - ACTIVITY stretcher states
//   pwm_gate - brightness gate used when LED_PWM_EN is defined
package led_status_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_ACT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } act_st_e;

  // Full scale (15) bypasses the gate so "max duty" is truly always-on.
  function automatic logic pwm_gate(input logic [3:0] duty, input logic [3:0] cnt);
    return (duty == 4'hF) || (cnt < duty);
  endfunction
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel -- mode decode, ACTIVITY stretcher FSM and
// optional PWM gate. The LED output is registered and reflects the mode /
// act inputs sampled on the same edge (one cycle latency).
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   i_mode       - channel mode (mode_e encoding)
//   i_act        - activity pulse (only honoured in ACTIVITY mode)
//   i_tick       - shared tick strobe
//   i_phase      - shared blink phase
//   i_duty       - 4-bit duty (LED_PWM_EN only)
//   i_pwm_cnt    - shared free-running PWM counter (LED_PWM_EN only)
//   o_led        - registered LED drive
// Config macro: LED_PWM_EN adds the PWM gate.
module led_channel
  import led_status_pkg::*;
#(
  parameter int STRETCH = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_act,
  input  logic              i_tick,
  input  logic              i_phase,
`ifdef LED_PWM_EN
  input  logic [3:0]        i_duty,
  input  logic [3:0]        i_pwm_cnt,
`endif
  output logic              o_led
);
  localparam int CNT_W = $clog2(STRETCH + 1);

  mode_e            w_mode;
  logic             w_gate;
  logic             w_last;
  act_st_e          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_led;

  assign w_mode = mode_e'(i_mode);

`ifdef LED_PWM_EN
  assign w_gate = pwm_gate(i_duty, i_pwm_cnt);
`else
  assign w_gate = 1'b1;
`endif

  // Tick that ends the current ON/GAP phase.
  assign w_last = i_tick && (r_cnt == CNT_W'(1));

  // The LED register is loaded with the value of the state being entered,
  // so ACTIVITY shows on the cycle right after act is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_led   <= 1'b0;
    end else if (w_mode != MODE_ACT) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      case (w_mode)
        MODE_ON:    r_led <= w_gate;
        MODE_BLINK: r_led <= i_phase & w_gate;
        default:    r_led <= 1'b0;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A coincident tick is deliberately not counted here.
          if (i_act) begin
            r_state <= ST_ON;
            r_cnt   <= CNT_W'(STRETCH);
            r_led   <= w_gate;
          end else begin
            r_led   <= 1'b0;
          end
        end
        ST_ON: begin
          if (i_act) r_pend <= 1'b1;
          if (w_last) begin
            r_state <= ST_GAP;
            r_cnt   <= CNT_W'(STRETCH);
            r_led   <= 1'b0;
          end else begin
            if (i_tick) r_cnt <= r_cnt - CNT_W'(1);
            r_led <= w_gate;
          end
        end
        ST_GAP: begin
          if (w_last) begin
            // Activity seen during ON/GAP (including this cycle) retriggers.
            r_pend <= 1'b0;
            if (r_pend || i_act) begin
              r_state <= ST_ON;
              r_cnt   <= CNT_W'(STRETCH);
              r_led   <= w_gate;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_led   <= 1'b0;
            end
          end else begin
            if (i_act)  r_pend <= 1'b1;
            if (i_tick) r_cnt  <= r_cnt - CNT_W'(1);
            r_led <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_pend  <= 1'b0;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign o_led = r_led;
endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel LED status controller. Holds the shared
// tick prescaler and blink phase generator and instantiates one
// led_channel per LED.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   mode       - MODE_W bits per channel, channel i at [MODE_W*i +: MODE_W]
//   act        - per-channel activity pulse
//   duty       - 4 bits per channel (only with LED_PWM_EN)
//   led        - registered LED drive
//   tick       - one-cycle strobe every TICK_DIV clocks
// Config macro: LED_PWM_EN enables per-channel PWM brightness.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int TICK_DIV   = 125000,
  parameter int BLINK_HALF = 250,
  parameter int STRETCH    = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MODE_W*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]        act,
`ifdef LED_PWM_EN
  input  logic [4*NUM_CH-1:0]      duty,
`endif
  output logic [NUM_CH-1:0]        led,
  output logic                     tick
);
  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink;
  logic          r_phase;
  logic          w_tick;

  // Tick is a decode of the prescaler register, so it is high exactly in
  // the cycle where the count sits at its terminal value.
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));
  assign tick   = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // One shared phase keeps every BLINK channel in lock-step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_blink == BW'(BLINK_HALF - 1)) begin
        r_blink <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= r_blink + BW'(1);
      end
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .STRETCH(STRETCH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_mode    (mode[MODE_W*i +: MODE_W]),
      .i_act     (act[i]),
      .i_tick    (w_tick),
      .i_phase   (r_phase),
`ifdef LED_PWM_EN
      .i_duty    (duty[4*i +: 4]),
      .i_pwm_cnt (r_pwm_cnt),
`endif
      .o_led     (led[i])
    );
  end
endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: directed bench for led_status_ctrl with
// NUM_CH=4, TICK_DIV=4, BLINK_HALF=3, STRETCH=2. Inputs change on the
// falling edge, outputs are sampled on the falling edge after each rising
// edge. ec counts rising edges since the last reset release.
// Config macro: LED_PWM_EN adds the duty port and the PWM checks.
module tb_led_status_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mode = 8'h55;
  logic [3:0] act = 4'h0;
  logic [3:0] led;
  logic       tick;
`ifdef LED_PWM_EN
  logic [15:0] duty = 16'hFFFF;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ec;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;
  end

  led_status_ctrl #(
    .NUM_CH(4), .TICK_DIV(4), .BLINK_HALF(3), .STRETCH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .act   (act),
`ifdef LED_PWM_EN
    .duty  (duty),
`endif
    .led   (led),
    .tick  (tick)
  );

  typedef struct {
    logic [7:0] mode;
    logic [3:0] act;
    logic [3:0] led;
    logic       tick;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (ec=%0d): got %0h, expected %0h", nm, ec, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // ch0 in ACTIVITY, others OFF. Act pulses sampled on edges p1/p2/p3,
  // mode forced OFF on edge off_at; led[0] expected high in [a1,b1]/[a2,b2].
  task automatic act_run(input string nm, input int p1, input int p2, input int p3,
                         input int off_at, input int a1, input int b1,
                         input int a2, input int b2, input int n);
    logic e;
    mode = 8'h03;
    act  = 4'h0;
    do_reset();
    for (int k = 1; k <= n; k++) begin
      mode = (k == off_at) ? 8'h00 : 8'h03;
      act  = {3'b000, (k == p1) || (k == p2) || (k == p3)};
      cyc();
      e = ((k >= a1) && (k <= b1)) || ((k >= a2) && (k <= b2));
      chk(nm, {28'd0, led}, {28'd0, 3'b000, e});
    end
    act = 4'h0;
  endtask

  initial begin
    // ch3..ch0 mode fields, then act, expected led, expected tick.
    vecs[0] = '{8'b10_10_10_10, 4'hF, 4'b0000, 1'b0}; // blink, phase still 0
    vecs[1] = '{8'b00_01_10_01, 4'h0, 4'b0101, 1'b0}; // mixed OFF/ON/BLINK/ON
    vecs[2] = '{8'b00_00_00_00, 4'hF, 4'b0000, 1'b1}; // OFF ignores act
    vecs[3] = '{8'b01_01_01_01, 4'hF, 4'b1111, 1'b0}; // ON ignores act
    vecs[4] = '{8'b11_11_11_11, 4'h0, 4'b0000, 1'b0}; // ACTIVITY idle
    vecs[5] = '{8'b01_00_01_00, 4'h0, 4'b1010, 1'b0};

    // Reset held with mode ON: outputs stay cleared.
    mode = 8'h55;
    cyc();
    cyc();
    chk("rst_led", {28'd0, led}, 32'h0);
    chk("rst_tick", {31'd0, tick}, 32'h0);

    // Release: tick on edges 3,7,... (high in 4th cycle), led follows ON.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("on_led", {28'd0, led}, 32'hF);
      chk("tick_period", {31'd0, tick}, {31'd0, (k % 4) == 3});
    end

    // Table of single-cycle mode vectors (edges 9..14).
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      act  = vecs[i].act;
      cyc();
      chk("vec_led", {28'd0, led}, {28'd0, vecs[i].led});
      chk("vec_tick", {31'd0, tick}, {31'd0, vecs[i].tick});
    end
    act = 4'h0;

    // Edge 15 has tick high; reset asserted mid-run clears outputs at once.
    mode = 8'h55;
    cyc();
    chk("pre_rst_led", {28'd0, led}, 32'hF);
    chk("pre_rst_tick", {31'd0, tick}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_led", {28'd0, led}, 32'h0);
    chk("async_rst_tick", {31'd0, tick}, 32'h0);

    // BLINK: phase flips on ticks at edges 12,24,..; led one edge later.
    mode = 8'hAA;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk("blink", {28'd0, led}, ((((k - 1) / 12) % 2) == 1) ? 32'hF : 32'h0);
    end

    // Ticks seen by the FSM on edges 4,8,12,16,20,24,...
    act_run("act_single",   2, 0,  0, 0,  2,  7,  0, -1, 30);
    act_run("act_on_retrig",2, 3,  0, 0,  2,  7, 16, 23, 36);
    act_run("act_gap_retrig",2,10, 0, 0,  2,  7, 16, 23, 36);
    act_run("act_with_tick",4, 0,  0, 0,  4, 11,  0, -1, 24);
    act_run("act_mode_off", 2, 3, 10, 5,  2,  4, 10, 15, 34);

`ifdef LED_PWM_EN
    begin
      logic [3:0] dv[3];
      int         ev[3];
      int         hi;
      int         any;
      dv[0] = 4'd4;  ev[0] = 4;
      dv[1] = 4'd0;  ev[1] = 0;
      dv[2] = 4'd15; ev[2] = 16;
      mode = 8'h55;
      for (int i = 0; i < 3; i++) begin
        duty = {4{dv[i]}};
        cyc();
        cyc();
        hi  = 0;
        any = 0;
        for (int k = 0; k < 16; k++) begin
          cyc();
          if (led == 4'hF) hi++;
          if (led != 4'h0) any++;
        end
        chk("pwm_all_hi", hi, ev[i]);
        chk("pwm_any_hi", any, ev[i]);
      end
      duty = 16'hFFFF;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
